// File: rtl/divu_seq.sv
// Multi-cycle restoring divider (DIVU; DIV too when SIGNED_DIV_EN is defined).
// Each iteration subtracts through a 4-bit-group carry-lookahead adder.
module divu_cla #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);
   logic [W-1:0] w_g, w_p, w_c;
   logic         w_cy;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Lookahead inside each group; group carries chain through G/P.
   always_comb begin
      w_c  = '0;
      w_cy = i_cin;
      for (int k = 0; k < W / 4; k++) begin
         w_c[4*k]   = w_cy;
         w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_cy);
         w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+1] & w_p[4*k] & w_cy);
         w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_cy);
         w_cy       = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_cy);
      end
   end

   assign o_sum  = w_p ^ w_c;
   assign o_cout = w_cy;
endmodule

// state | meaning
// IDLE  | waiting for start; q/r hold the last result
// RUN   | one restoring step per clock, WIDTH steps
// FIX   | (SIGNED_DIV_EN only) apply signs to q/r and publish
module divu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
`ifdef SIGNED_DIV_EN
   input  logic             i_is_signed,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_r
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

`ifdef SIGNED_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;
`endif

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_dvd, r_dsr, r_acc, r_q, r_r;
   logic [CW-1:0]    r_cnt;
   logic             r_done;
   logic             w_load, w_last, w_cout, w_qbit;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff, w_acc_nxt, w_dvd_nxt, w_dvd_in, w_dsr_in;

`ifdef SIGNED_DIV_EN
   logic r_neg_q, r_neg_r;
   logic w_neg_a, w_neg_b;
   assign w_neg_a  = i_is_signed & i_dividend[WIDTH-1];
   assign w_neg_b  = i_is_signed & i_divisor[WIDTH-1];
   assign w_dvd_in = w_neg_a ? -i_dividend : i_dividend;
   assign w_dsr_in = w_neg_b ? -i_divisor : i_divisor;
`else
   assign w_dvd_in = i_dividend;
   assign w_dsr_in = i_divisor;
`endif

   // acc < divisor always holds, so only the shifted value needs the extra bit.
   assign w_shift = {r_acc, r_dvd[WIDTH-1]};

   divu_cla #(.W(WIDTH)) u_cla (
      .i_a    (w_shift[WIDTH-1:0]),
      .i_b    (~r_dsr),
      .i_cin  (1'b1),
      .o_sum  (w_diff),
      .o_cout (w_cout)
   );

   assign w_qbit    = w_shift[WIDTH] | w_cout;
   assign w_acc_nxt = w_qbit ? w_diff : w_shift[WIDTH-1:0];
   assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_qbit};
   assign w_last    = (r_state == S_RUN) && (r_cnt == CW'(1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
`ifdef SIGNED_DIV_EN
            if (w_last) w_state_nxt = S_FIX;
`else
            if (w_last) w_state_nxt = S_IDLE;
`endif
         end
`ifdef SIGNED_DIV_EN
         S_FIX:   w_state_nxt = S_IDLE;
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_done  <= 1'b0;
`ifdef SIGNED_DIV_EN
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_dvd   <= w_dvd_in;
            r_dsr   <= w_dsr_in;
            r_acc   <= '0;
            r_cnt   <= CNT_INIT;
`ifdef SIGNED_DIV_EN
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
`endif
         end else if (r_state == S_RUN) begin
            r_dvd <= w_dvd_nxt;
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CW'(1);
`ifndef SIGNED_DIV_EN
            if (w_last) begin
               r_q    <= w_dvd_nxt;
               r_r    <= w_acc_nxt;
               r_done <= 1'b1;
            end
`endif
         end
`ifdef SIGNED_DIV_EN
         else if (r_state == S_FIX) begin
            r_q    <= r_neg_q ? -r_dvd : r_dvd;
            r_r    <= r_neg_r ? -r_acc : r_acc;
            r_done <= 1'b1;
         end
`endif
      end
   end

   assign o_busy = (r_state != S_IDLE);
   assign o_done = r_done;
   assign o_q    = r_q;
   assign o_r    = r_r;
endmodule

// File: tb/tb_divu_seq.sv
// Directed self-checking bench for divu_seq: vector table plus reset and handshake sequences.
module tb_divu_seq;
   localparam int W = 32;
`ifdef SIGNED_DIV_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sgn;
      logic [W-1:0] q;
      logic [W-1:0] r;
      string        nm;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic         busy, done;
   logic [W-1:0] q, r;
   logic         is_signed = 1'b0;

   int errors = 0;
   int checks = 0;
   vec_t vt[$];

   divu_seq #(.WIDTH(W)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_dividend (dividend),
      .i_divisor  (divisor),
`ifdef SIGNED_DIV_EN
      .i_is_signed(is_signed),
`endif
      .o_busy     (busy),
      .o_done     (done),
      .o_q        (q),
      .o_r        (r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input string nm);
      int n, bc;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b; is_signed = sgn;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = ~a; divisor = $urandom; is_signed = ~sgn;
      bc = busy ? 1 : 0;
      n = 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (busy) bc++;
      end
      chk({nm, " latency"}, n, LAT);
      chk({nm, " busy_cycles"}, bc, LAT);
      chk({nm, " q"}, q, eq);
      chk({nm, " r"}, r, er);
      @(posedge clk); #1;
      chk({nm, " done_pulse"}, {31'd0, done}, 0);
      chk({nm, " q_hold"}, q, eq);
   endtask

   initial begin
      int first, second;
      logic [W-1:0] ea, eb;

      vt.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,    "basic"});
      vt.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,    "max_by_1"});
      vt.push_back('{32'd5,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd5,    "5_by_max"});
      vt.push_back('{32'd0,          32'd9,          1'b0, 32'd0,          32'd0,    "zero_num"});
      vt.push_back('{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234, "div_zero"});
      vt.push_back('{32'd1000000,    32'd3,          1'b0, 32'd333333,     32'd1,    "mil_by_3"});
      vt.push_back('{32'hDEAD_BEEF,  32'h0001_0000,  1'b0, 32'h0000_DEAD,  32'h0000_BEEF, "shift16"});
      vt.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,    "unsigned_big"});
`ifdef SIGNED_DIV_EN
      vt.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, "s_m7_by_2"});
      vt.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,    "s_minneg_by_m1"});
      vt.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,    "s_7_by_m2"});
      vt.push_back('{32'hFFFF_FFF8,  32'd0,          1'b1, 32'd1,          32'hFFFF_FFF8, "s_neg_by_0"});
      vt.push_back('{32'd20,         32'd0,          1'b1, 32'hFFFF_FFFF,  32'd20,   "s_pos_by_0"});
`endif

      #3;
      chk("rst busy", {31'd0, busy}, 0);
      chk("rst done", {31'd0, done}, 0);
      chk("rst q", q, 0);
      chk("rst r", r, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vt.size(); i++)
         do_op(vt[i].a, vt[i].b, vt[i].sgn, vt[i].q, vt[i].r, vt[i].nm);

      // Reset in the middle of an operation.
      @(negedge clk);
      start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midrst busy", {31'd0, busy}, 0);
      chk("midrst done", {31'd0, done}, 0);
      chk("midrst q", q, 0);
      chk("midrst r", r, 0);
      @(negedge clk);
      reset = 1'b0;
      do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "after_rst");

      // Start held high with changing operands; back-to-back via start during done.
      first = -1; second = -1; ea = '0; eb = '1;
      @(negedge clk);
      start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
      for (int c = 0; c < 200 && second < 0; c++) begin
         @(posedge clk); #1;
         if (done) begin
            if (first < 0) begin
               first = c;
               chk("hs first q", q, 32'd14);
               chk("hs first r", r, 32'd2);
            end else begin
               second = c;
               chk("hs second q", q, ea / eb);
               chk("hs second r", r, ea % eb);
            end
         end
         if (first >= 0 && c == first + 10)
            chk("hs hold q", q, 32'd14);
         @(negedge clk);
         if (c < 39) begin
            dividend = $urandom;
            divisor  = $urandom_range(1, 5000);
         end else begin
            start = 1'b0;
         end
         if (c == first) begin
            ea = dividend;
            eb = divisor;
         end
      end
      chk("hs first latency", first, LAT);
      chk("hs second latency", second, 2 * LAT + 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/divu_seq.md
Name: divu_seq

Overview:
- Multi-cycle restoring divider for the CPU datapath; consumes the 32-bit carry-lookahead adder result once per iteration.
- Executes DIVU (DIV when the optional feature is compiled in) and writes the quotient to LO and the remainder to HI.
- The control unit stalls the pipeline while busy=1 and captures q/r when done=1.
- The iteration subtractor is the team's carry-lookahead adder built from 4-bit groups, used as a - b (b inverted, carry_in=1); carry_out=1 means no borrow.

Parameters:
WIDTH, 32, operand/quotient/remainder width; must be a multiple of 4 (CLA grouping).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled at a rising edge only while busy=0
dividend  input  WIDTH  numerator, sampled with start
divisor  input  WIDTH  denominator, sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when q/r become valid
q  output  WIDTH  quotient (to LO)
r  output  WIDTH  remainder (to HI)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, q=0, r=0; iteration counter=0. Reset asserted mid-operation aborts immediately with no partial result. The first operation may start at the first rising edge after reset deasserts.
- States: IDLE, RUN (plus FIX when SIGNED_DIV_EN is defined).
- IDLE:
  - start=1 at edge E0 → load the working dividend register, the divisor register and remainder accumulator=0.
  - counter=WIDTH, busy=1, done=0, go to RUN.
  - q and r keep their previous values until completion.
- RUN: each edge performs one restoring step:
  - shift {acc, dvd} left by 1;
  - trial = acc_shifted - divisor, computed through the CLA;
  - if no borrow, acc=trial and the new quotient LSB=1; otherwise acc is unchanged and the LSB=0;
  - counter decrements.
- Completion: the edge that performs iteration WIDTH (E_WIDTH) writes q=quotient and r=acc, sets busy=0 and done=1, and returns to IDLE.
  - Latency: start edge plus WIDTH edges, i.e. q/r/done are visible in the cycle after edge E_WIDTH.
- done is high for exactly one cycle. q/r hold until the next completion.
- start while busy=1 is ignored and not queued.
- start asserted in the same cycle done=1 (state IDLE) is accepted, giving back-to-back operations with no bubble.
- Divide by zero: no special case; the algorithm yields q={WIDTH{1}} and r=dividend, with normal latency.
- Arithmetic: the accumulator is WIDTH+1 bits internally so the shifted value cannot overflow. The quotient is truncated. r < divisor whenever divisor≠0.
- dividend/divisor changing after E0 has no effect.

Optional Feature:
Macro: SIGNED_DIV_EN
- Defined:
  - Adds port is_signed (input, 1), sampled with start.
  - When is_signed=1, operand magnitudes are taken at E0, the unsigned core runs, then one FIX cycle negates q if the operand signs differ and gives r the sign of the dividend (MIPS DIV semantics).
  - Latency is WIDTH+1 edges for both signed and unsigned requests, so stall timing is uniform.
  - Most-negative ÷ -1 yields q=0x80000000, r=0.
  - Signed divide by zero: q = +all-ones for a non-negative dividend and +1 for a negative dividend (inherent result, then sign fix); r=dividend.
- Not defined: no is_signed port, no FIX state, unsigned only, latency WIDTH.

Test Plan:
1. Reset mid-op: start 100/7, assert reset at iteration 10 → busy=0, done=0, q=0, r=0 immediately; a new start after release works.
2. Basic: dividend=100, divisor=7 → done exactly 32 edges after the start edge; q=14, r=2; busy high for exactly 32 cycles.
3. Extremes: 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0. 5/0xFFFFFFFF → q=0, r=5. 0/9 → q=0, r=0.
4. Divide by zero: 1234/0 → q=0xFFFFFFFF, r=1234, normal latency.
5. Handshake: start held high for 40 cycles with changing operands → only the first request is executed; a start coincident with done launches the second op, whose done follows 32 edges later; q/r hold between completions.
6. (SIGNED_DIV_EN) -7/2 signed → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1), done at 33 edges. 0x80000000/0xFFFFFFFF signed → q=0x80000000, r=0.
